pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Valid/ready pipeline stage with one main slot and one skid slot, so the
//   upstream ready is a pure register output (no out_ready -> in_ready path).
//   Control bits are zeroed on bubbles and on flush. The payload holds its
//   value through bubbles. A saturating counter tracks back-pressured cycles.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream has an instruction
//   in_ready   : stage can accept (skid slot empty)
//   in_ctrl    : upstream control bundle [CTRL_W]
//   in_data    : upstream payload [DATA_W]
//   flush      : synchronous kill of held and incoming instructions
//   out_valid  : main slot holds an instruction
//   out_ready  : downstream accepts
//   out_ctrl   : control bundle, zero whenever out_valid=0
//   out_data   : payload of the main slot
//   stall_cnt  : saturating count of cycles with out_valid && !out_ready
//   clr_cnt    : synchronous clear of stall_cnt (wins over increment)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Slot state
    logic              mainValid, mainValidNxt;
    logic [CTRL_W-1:0] mainCtrl,  mainCtrlNxt;
    logic [DATA_W-1:0] mainData,  mainDataNxt;
    logic              skidValid, skidValidNxt;
    logic [CTRL_W-1:0] skidCtrl,  skidCtrlNxt;
    logic [DATA_W-1:0] skidData,  skidDataNxt;
    logic [CNT_W-1:0]  stallCnt,  stallCntNxt;

    logic inFire;
    logic mainLoad;

    // Ready depends only on the skid register
    assign inFire   = in_valid && !skidValid;
    assign mainLoad = !mainValid || out_ready;

    // Next-state for both slots and the stall counter
    always_comb begin
        mainValidNxt = mainValid;
        mainCtrlNxt  = mainCtrl;
        mainDataNxt  = mainData;
        skidValidNxt = skidValid;
        skidCtrlNxt  = skidCtrl;
        skidDataNxt  = skidData;
        stallCntNxt  = stallCnt;

        if (flush) begin
            // Kill everything; payload registers keep their old values
            mainValidNxt = 1'b0;
            mainCtrlNxt  = '0;
            skidValidNxt = 1'b0;
            skidCtrlNxt  = '0;
        end else if (mainLoad) begin
            if (skidValid) begin
                // Older skid entry goes first; input is blocked while skid is full
                mainValidNxt = 1'b1;
                mainCtrlNxt  = skidCtrl;
                mainDataNxt  = skidData;
                skidValidNxt = 1'b0;
                skidCtrlNxt  = '0;
            end else if (inFire) begin
                mainValidNxt = 1'b1;
                mainCtrlNxt  = in_ctrl;
                mainDataNxt  = in_data;
            end else begin
                // Bubble: control zeroed, payload held
                mainValidNxt = 1'b0;
                mainCtrlNxt  = '0;
            end
        end else if (inFire) begin
            // Main occupied and stalled: park the input in the skid slot
            skidValidNxt = 1'b1;
            skidCtrlNxt  = in_ctrl;
            skidDataNxt  = in_data;
        end

        if (clr_cnt) begin
            stallCntNxt = '0;
        end else if (mainValid && !out_ready && (stallCnt != CNT_MAX)) begin
            stallCntNxt = stallCnt + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
            mainData  <= '0;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
            skidData  <= '0;
            stallCnt  <= '0;
        end else begin
            mainValid <= mainValidNxt;
            mainCtrl  <= mainCtrlNxt;
            mainData  <= mainDataNxt;
            skidValid <= skidValidNxt;
            skidCtrl  <= skidCtrlNxt;
            skidData  <= skidDataNxt;
            stallCnt  <= stallCntNxt;
        end
    end

    // Outputs straight from registers; ctrl masked so a bubble never shows control
    assign in_ready  = !skidValid;
    assign out_valid = mainValid;
    assign out_ctrl  = mainValid ? mainCtrl : '0;
    assign out_data  = mainData;
    assign stall_cnt = stallCnt;

endmodule
